// File: rtl/indicator_pkg.sv
// Shared encodings, types and helpers for the indicator lamp sequencer.
package indicator_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_RIGHT  = 2'b01;
    localparam logic [1:0] MODE_LEFT   = 2'b10;
    localparam logic [1:0] MODE_HAZARD = 2'b11;

    // State encoding doubles as the reported mode, so mode is the state register itself.
    typedef enum logic [1:0] {
        ST_OFF    = MODE_OFF,
        ST_RIGHT  = MODE_RIGHT,
        ST_LEFT   = MODE_LEFT,
        ST_HAZARD = MODE_HAZARD
    } state_e;

    // Arbitration inputs after stalk conflict resolution.
    typedef struct packed {
        logic haz;
        logic left;
        logic right;
    } ind_req_t;

    // Bits needed to hold values 0..value-1, never less than 1.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/indicator_blink_timer.sv
// Blink phase generator: counts half-periods and toggles the lamp phase on each wrap.
module indicator_blink_timer
    import indicator_pkg::*;
#(
    parameter int  HALF_PER = 25,
    localparam int CW       = clog2(HALF_PER),
    localparam int HW       = clog2(HALF_PER + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,     // lamps dark, counter idle
    input  logic          restart,   // start a fresh on-phase
    input  logic [HW-1:0] half_per,  // current half-period, may change any cycle
    output logic          phase,     // phase that is held for the coming cycle
    output logic          on_done    // an on-phase ends on this edge
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          wrap;

    // Wrap uses >= so a half-period that shrinks below the count wraps at once.
    always_comb begin
        wrap    = HW'(cnt_q) >= (half_per - HW'(1));
        on_done = phase_q & wrap;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (wrap) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CW'(1);
        end
    end

    assign phase = phase_d;

    // Counter and phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/indicator_flash_ctrl.sv
// Indicator lamp sequencer: hazard/stalk arbitration, tap-triggered comfort flashing,
// bulb-fail fast blink and registered lamp/mode outputs.
module indicator_flash_ctrl
    import indicator_pkg::*;
#(
    parameter int HALF_PER    = 25,
    parameter int TAP_CYCLES  = 8,
    parameter int TAP_FLASHES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       haz_req,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       bulb_fail_l,
    input  logic       bulb_fail_r,
    output logic       lamp_l,
    output logic       lamp_r,
    output logic [1:0] mode,
    output logic       comfort
);

    localparam int HW = clog2(HALF_PER + 1);
    localparam int PW = clog2(TAP_CYCLES + 1);
    localparam int FW = clog2(TAP_FLASHES + 1);

    state_e        st_q, st_d;
    logic [PW-1:0] press_q, press_d;
    logic          press_left_q, press_left_d;
    logic [FW-1:0] flash_q, flash_d;
    logic          comfort_q, comfort_d;
    logic          lamp_l_q, lamp_l_d;
    logic          lamp_r_q, lamp_r_d;

    ind_req_t      req;
    logic [HW-1:0] half_per;
    logic          fail_cur, restart, clear, phase_nxt, on_done;
    logic          press_tap, flash_full, own, opp;
    logic [FW-1:0] flash_tot;

    // Both stalks at once is treated as no stalk at all.
    assign req = '{haz: haz_req, left: left_req & ~right_req, right: right_req & ~left_req};

    // Fast blink only when a lamp that the current mode actually drives is open-circuit.
    assign fail_cur = (bulb_fail_l & (st_q == ST_LEFT  || st_q == ST_HAZARD)) |
                      (bulb_fail_r & (st_q == ST_RIGHT || st_q == ST_HAZARD));
    assign half_per = fail_cur ? HW'(HALF_PER / 2) : HW'(HALF_PER);

    // On-phases completed including the one ending on this edge.
    assign flash_tot  = (on_done && flash_q != FW'(TAP_FLASHES)) ? flash_q + FW'(1) : flash_q;
    assign flash_full = (flash_tot == FW'(TAP_FLASHES));
    assign press_tap  = (press_q < PW'(TAP_CYCLES));

    // Next state and comfort flag: hazard, then held stalk, then comfort, then off.
    always_comb begin
        st_d      = st_q;
        comfort_d = comfort_q;
        own       = 1'b0;
        opp       = 1'b0;
        if (req.haz) begin
            st_d      = ST_HAZARD;
            comfort_d = 1'b0;
        end else begin
            case (st_q)
                ST_OFF, ST_HAZARD: begin
                    comfort_d = 1'b0;
                    if (req.left)       st_d = ST_LEFT;
                    else if (req.right) st_d = ST_RIGHT;
                    else                st_d = ST_OFF;
                end
                default: begin
                    own = (st_q == ST_LEFT) ? req.left  : req.right;
                    opp = (st_q == ST_LEFT) ? req.right : req.left;
                    if (opp) begin
                        st_d      = (st_q == ST_LEFT) ? ST_RIGHT : ST_LEFT;
                        comfort_d = 1'b0;
                    end else if (own) begin
                        comfort_d = 1'b0;
                    end else if (comfort_q || press_tap) begin
                        // Stop on the edge closing the last on-phase: no trailing dark phase.
                        if (flash_full) begin
                            st_d      = ST_OFF;
                            comfort_d = 1'b0;
                        end else begin
                            comfort_d = 1'b1;
                        end
                    end else begin
                        st_d      = ST_OFF;
                        comfort_d = 1'b0;
                    end
                end
            endcase
        end
    end

    // Phase control, press/flash counters and lamp drive for the coming cycle.
    always_comb begin
        restart      = (st_d != st_q) && (st_d != ST_OFF);
        clear        = (st_d == ST_OFF);
        flash_d      = (st_d != st_q) ? '0 : flash_tot;
        press_d      = '0;
        press_left_d = press_left_q;
        if (req.left) begin
            press_left_d = 1'b1;
            press_d      = (press_left_q && press_q != '0) ?
                           ((press_q == PW'(TAP_CYCLES)) ? press_q : press_q + PW'(1)) : PW'(1);
        end else if (req.right) begin
            press_left_d = 1'b0;
            press_d      = (!press_left_q && press_q != '0) ?
                           ((press_q == PW'(TAP_CYCLES)) ? press_q : press_q + PW'(1)) : PW'(1);
        end
        lamp_l_d = phase_nxt & (st_d == ST_LEFT  || st_d == ST_HAZARD);
        lamp_r_d = phase_nxt & (st_d == ST_RIGHT || st_d == ST_HAZARD);
    end

    indicator_blink_timer #(.HALF_PER(HALF_PER)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .restart  (restart),
        .half_per (half_per),
        .phase    (phase_nxt),
        .on_done  (on_done)
    );

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q         <= ST_OFF;
            press_q      <= '0;
            press_left_q <= 1'b0;
            flash_q      <= '0;
            comfort_q    <= 1'b0;
            lamp_l_q     <= 1'b0;
            lamp_r_q     <= 1'b0;
        end else begin
            st_q         <= st_d;
            press_q      <= press_d;
            press_left_q <= press_left_d;
            flash_q      <= flash_d;
            comfort_q    <= comfort_d;
            lamp_l_q     <= lamp_l_d;
            lamp_r_q     <= lamp_r_d;
        end
    end

    assign mode    = st_q;
    assign lamp_l  = lamp_l_q;
    assign lamp_r  = lamp_r_q;
    assign comfort = comfort_q;

endmodule

// File: tb/tb_indicator_flash_ctrl.sv
// Bench for indicator_flash_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the lamp sequencer.
module tb_indicator_flash_ctrl;

    localparam int HP = 4;
    localparam int TC = 8;
    localparam int TF = 3;

    logic       clk = 1'b0;
    logic       reset, haz_req, left_req, right_req, bulb_fail_l, bulb_fail_r;
    logic       lamp_l, lamp_r, comfort;
    logic [1:0] mode;

    int vectors = 0;
    int miscompares = 0;

    indicator_flash_ctrl #(.HALF_PER(HP), .TAP_CYCLES(TC), .TAP_FLASHES(TF)) dut (
        .clk         (clk),
        .reset       (reset),
        .haz_req     (haz_req),
        .left_req    (left_req),
        .right_req   (right_req),
        .bulb_fail_l (bulb_fail_l),
        .bulb_fail_r (bulb_fail_r),
        .lamp_l      (lamp_l),
        .lamp_r      (lamp_r),
        .mode        (mode),
        .comfort     (comfort)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (mode 0 off, 1 right, 2 left, 3 hazard) ----------------
    int m_mode = 0, m_on = 0, m_cnt = 0, m_press = 0, m_pleft = 0, m_flash = 0, m_comfort = 0;

    always @(posedge clk) begin : model
        int le, re, hp, ended, fl, nm, nc, own, opp;
        if (reset) begin
            m_mode = 0; m_on = 0; m_cnt = 0; m_press = 0; m_pleft = 0; m_flash = 0; m_comfort = 0;
        end else begin
            le = (left_req && !right_req) ? 1 : 0;
            re = (right_req && !left_req) ? 1 : 0;
            hp = HP;
            if ((bulb_fail_l && (m_mode == 2 || m_mode == 3)) ||
                (bulb_fail_r && (m_mode == 1 || m_mode == 3))) hp = HP / 2;
            ended = (m_on != 0 && m_cnt + 1 >= hp) ? 1 : 0;
            fl = (m_flash + ended > TF) ? TF : m_flash + ended;
            nm = m_mode;
            nc = m_comfort;
            if (haz_req) begin
                nm = 3; nc = 0;
            end else if (m_mode == 0 || m_mode == 3) begin
                nc = 0;
                nm = le ? 2 : (re ? 1 : 0);
            end else begin
                own = (m_mode == 2) ? le : re;
                opp = (m_mode == 2) ? re : le;
                if (opp) begin
                    nm = 3 - m_mode; nc = 0;
                end else if (own) begin
                    nc = 0;
                end else if (m_comfort != 0 || m_press < TC) begin
                    if (fl >= TF) begin nm = 0; nc = 0; end
                    else nc = 1;
                end else begin
                    nm = 0;
                end
            end
            if (nm == 0) begin
                m_on = 0; m_cnt = 0;
            end else if (nm != m_mode) begin
                m_on = 1; m_cnt = 0;
            end else if (m_cnt + 1 >= hp) begin
                m_on = (m_on != 0) ? 0 : 1; m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_flash = (nm != m_mode) ? 0 : fl;
            if (le) begin
                m_press = (m_pleft != 0 && m_press > 0) ? ((m_press >= TC) ? TC : m_press + 1) : 1;
                m_pleft = 1;
            end else if (re) begin
                m_press = (m_pleft == 0 && m_press > 0) ? ((m_press >= TC) ? TC : m_press + 1) : 1;
                m_pleft = 0;
            end else begin
                m_press = 0;
            end
            m_mode = nm;
            m_comfort = nc;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin : compare
        int el, er;
        el = (m_on != 0 && (m_mode == 2 || m_mode == 3)) ? 1 : 0;
        er = (m_on != 0 && (m_mode == 1 || m_mode == 3)) ? 1 : 0;
        vectors++;
        if (mode !== 2'(m_mode) || lamp_l !== el[0] || lamp_r !== er[0] || comfort !== m_comfort[0]) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t got mode=%b lamp_l=%b lamp_r=%b comfort=%b, want mode=%0d lamp_l=%0d lamp_r=%0d comfort=%0d",
                     $time, mode, lamp_l, lamp_r, comfort, m_mode, el, er, m_comfort);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic h, input logic l, input logic r, input logic fl, input logic fr);
        haz_req = h; left_req = l; right_req = r; bulb_fail_l = fl; bulb_fail_r = fr;
    endtask

    initial begin : stim
        logic [7:0]  s8l, s8r;
        logic [11:0] s12;
        logic [19:0] s20;
        logic [23:0] s24, c24, m24;
        int cycles;

        reset = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1: reset with hazard held, then hazard on the first edge out of reset
        repeat (3) tick();
        check("reset_outputs", {mode, lamp_l, lamp_r, comfort}, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) check("haz_entry_mode", mode, 3);
            s8l = {s8l[6:0], lamp_l};
            s8r = {s8r[6:0], lamp_r};
        end
        check("haz_lamp_l_seq", s8l, 8'b1111_0000);
        check("haz_lamp_r_seq", s8r, 8'b1111_0000);
        haz_req = 1'b0;
        tick();
        check("haz_off", mode, 0);

        // 2: long left hold, release goes straight off
        left_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) check("left_entry_mode", mode, 2);
            if (lamp_r) check("left_lamp_r_quiet", lamp_r, 0);
            s20 = {s20[18:0], lamp_l};
        end
        check("left_lamp_l_seq", s20, 20'b1111_0000_1111_0000_1111);
        left_req = 1'b0;
        tick();
        check("left_release_off", {mode, lamp_l, comfort}, 0);

        // 3: right tap -> three comfort flashes, off on the edge closing the third
        right_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 3) right_req = 1'b0;
            tick();
            s24 = {s24[22:0], lamp_r};
            c24 = {c24[22:0], comfort};
            m24 = {m24[22:0], (mode != 2'b00)};
        end
        check("tap_lamp_r_seq", s24, 24'b1111_0000_1111_0000_1111_0000);
        check("tap_comfort_seq", c24, 24'b0001_1111_1111_1111_1111_0000);
        check("tap_mode_active", m24, 24'b1111_1111_1111_1111_1111_0000);

        // 4a: left held, hazard pulse restarts phase both ways
        left_req = 1'b1;
        repeat (5) tick();
        haz_req = 1'b1;
        tick();
        check("pulse_haz_entry", {mode, lamp_l, lamp_r}, 4'b1111);
        repeat (9) tick();
        haz_req = 1'b0;
        tick();
        check("pulse_back_left", {mode, lamp_l, lamp_r}, 4'b1010);
        repeat (3) tick();
        left_req = 1'b0;
        tick();
        check("pulse_left_release", mode, 0);

        // 4b: tap then hazard pulse, comfort must not come back
        left_req = 1'b1;
        repeat (3) tick();
        left_req = 1'b0;
        tick();
        check("tap2_comfort", {mode, comfort}, 3'b101);
        haz_req = 1'b1;
        tick();
        check("tap2_haz_cancels", {mode, comfort}, 3'b110);
        repeat (9) tick();
        haz_req = 1'b0;
        tick();
        check("tap2_after_haz", {mode, lamp_l, lamp_r, comfort}, 0);

        // 5: bulb fail fast blink, cleared mid-phase
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 4) bulb_fail_l = 1'b0;
            s12 = {s12[10:0], lamp_l};
        end
        check("bulb_fail_seq", s12, 12'b1100_1111_0000);
        left_req = 1'b0;
        tick();
        check("bulb_release_off", mode, 0);

        // 6: both stalks is no request; dropping one selects the other
        left_req = 1'b1; right_req = 1'b1;
        tick();
        tick();
        check("both_stalks_off", {mode, lamp_l, lamp_r}, 0);
        right_req = 1'b0;
        tick();
        check("drop_right_left", {mode, lamp_l}, 3'b101);
        left_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // randomized traffic, checked every cycle by the compare process
        cycles = 0;
        while (cycles < 4000) begin : rnd
            int len, pick;
            pick = $urandom_range(0, 9);
            haz_req     = ($urandom_range(0, 9) == 0);
            left_req    = (pick == 5 || pick == 6 || pick == 9);
            right_req   = (pick == 7 || pick == 8 || pick == 9);
            bulb_fail_l = ($urandom_range(0, 5) == 0);
            bulb_fail_r = ($urandom_range(0, 5) == 0);
            reset       = ($urandom_range(0, 60) == 0);
            len = (pick < 5) ? $urandom_range(1, 24) : $urandom_range(1, 12);
            if (reset) len = 1;
            repeat (len) tick();
            reset = 1'b0;
            cycles += len;
        end

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
